fd_period_monitor: RTL and testbench
====================================

# fd_period_monitor

Measures the period of a divided clock (such as the divide-by-4 divider output) in `clk` cycles and declares frequency lock. It sits at the consuming end of the frequency-divider path of the FMDLL. It compares each measured period against an expected value within a tolerance, and reports mismatches and missing-edge timeouts to the loop control logic.

## Interface
Parameters:
- CNT_W, 8, width of the period counter and of `period`
- EXP_PERIOD, 4, expected `div_in` period in `clk` cycles
- TOL, 0, allowed absolute deviation from EXP_PERIOD
- LOCK_CNT, 4, consecutive matching periods required to lock (≥1)
- UNLOCK_CNT, 2, consecutive mismatching periods required to drop lock (≥1)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- div_in  input  1  divided clock under test; may be asynchronous to `clk`
- period  output  CNT_W  last measured period in `clk` cycles
- period_vld  output  1  one-cycle pulse when `period` is updated
- match_err  output  1  one-cycle pulse when a measured period is out of tolerance
- timeout  output  1  one-cycle pulse when no `div_in` rising edge is seen for 2^CNT_W−1 cycles
- locked  output  1  frequency lock indicator

**Reset:** reset is rst_n, asynchronous, active-low; clock is clk. While `rst_n` is low, every register clears to 0:
- all outputs
- synchronizer flops
- counters
- first-edge flag
- FSM state, which is UNLOCKED

## Operation
- **Synchronizer:** `div_in` passes through a 2-flop synchronizer (s1, s2) and then an edge register s3. The rise condition is `rise = s2 & ~s3`.
- **Period counter `cnt`:**
  - On `rise`: `cnt` loads 1.
  - Otherwise: `cnt` increments, saturating at 2^CNT_W−1.
- **First-edge flag:**
  - The first `rise` after reset or after a timeout only sets the flag.
  - No measurement is produced for that edge.
- **Measurement:** each `rise` with the flag set registers `period <= cnt` and pulses `period_vld`.
- **Match rule:** `match = (period_meas >= EXP_PERIOD−TOL) && (period_meas <= EXP_PERIOD+TOL)`.
  - The comparison uses unsigned arithmetic that is CNT_W+1 bits wide.
  - The lower bound clamps at 0.
- **match_err:** pulses in the same cycle as `period_vld` whenever `match` is false.
- **Timeout:** when `cnt` reaches saturation, the block:
  - pulses `timeout` once, on entry to saturation;
  - clears the first-edge flag;
  - forces the FSM to UNLOCKED and clears both counters.
- **FSM:** uses a good counter `good` and a bad counter `bad`. Transitions are evaluated only when a measurement is produced, except for timeout.
  - **UNLOCKED:**
    - match: `good` ← 1; go to LOCKED if LOCK_CNT == 1, else ACQUIRE.
    - mismatch: stay in UNLOCKED.
  - **ACQUIRE:**
    - match: `good`++; when `good+1 == LOCK_CNT`, go to LOCKED and clear `bad`.
    - mismatch: `good` ← 0; go to UNLOCKED.
  - **LOCKED:**
    - match: `bad` ← 0.
    - mismatch: `bad`++; when `bad+1 == UNLOCK_CNT`, go to UNLOCKED and clear `good`.
- **locked output:** `locked` = (state == LOCKED), registered.
- **Simultaneous events:** `rise` in the cycle that would saturate `cnt` counts as an edge, so no timeout is raised.

## Timing
- Let `div_in` be first sampled high at `clk` edge k.
- Edge k+1: s2 = 1, so `rise` is true combinationally.
- Edge k+2: `period`, `period_vld`, `match_err`, FSM state and `locked` all update together. The pulses last one cycle.
- Latency from a `div_in` rising edge to `period_vld` is therefore 2–3 `clk` cycles, depending on sampling phase.
- **Steady divide-by-4 input:**
  - `rise` occurs every 4 cycles.
  - The first `rise` is discarded, so `period` = 4 from the second edge on.
  - `locked` asserts on the edge carrying the LOCK_CNT-th valid measurement.
- `timeout` asserts 2^CNT_W−1 cycles after the last `rise`.
- **Mid-operation reset:** all state clears asynchronously. After release, the first `rise` is again discarded.

## Test plan
- **Lock acquisition:** drive `div_in` from a divide-by-4 of `clk` (idle high after reset release), default parameters.
  - Expect `period_vld` every 4 cycles with `period` = 4 and no `match_err`.
  - Expect `locked` = 1 at the 4th `period_vld`.
- **Loss of lock on wrong period:** lock first, then switch to a divide-by-6 input.
  - Expect `period` = 6 with `match_err` pulses.
  - Expect `locked` to drop at the 2nd mismatch.
  - After switching back to divide-by-4, expect re-lock after 4 matches.
- **Tolerance:** with TOL = 1, feed alternating periods 3 and 5.
  - Expect no `match_err` and `locked` after 4 measurements.
  - A period of 6 gives `match_err`.
- **Isolated glitch while locked:** lock, inject one period of 7, then resume period 4.
  - Expect one `match_err` and `locked` staying 1 (bad < UNLOCK_CNT).
- **Timeout:** lock, then hold `div_in` constant.
  - Expect `timeout` as a single pulse 255 cycles after the last `rise`, with `locked` = 0 on the same edge.
  - On resume, the first edge is discarded.
- **Reset mid-acquire:** assert `rst_n` low after 2 matches.
  - Expect all outputs = 0 immediately.
  - After release, expect lock only after 1 discarded edge plus 4 matches.

Source files
------------

// File: rtl/fd_period_monitor.sv
// -----------------------------------------------------------------------------
// fd_period_monitor
//
// Measures the period of a divided clock (div_in) in clk cycles, compares each
// measurement against EXP_PERIOD +/- TOL and tracks frequency lock with a
// small acquire/lock FSM. Missing div_in edges are reported as a timeout
// when the period counter saturates.
//
// Latency: a div_in rising edge first sampled at clk edge k produces a
// combinational rise in cycle k+1, and every registered output (period,
// period_vld, match_err, locked) updates together on edge k+2.
// -----------------------------------------------------------------------------
module fd_period_monitor #(
   parameter int CNT_W      = 8,  // period counter / period output width
   parameter int EXP_PERIOD = 4,  // expected div_in period in clk cycles
   parameter int TOL        = 0,  // allowed absolute deviation from EXP_PERIOD
   parameter int LOCK_CNT   = 4,  // consecutive matches needed to lock
   parameter int UNLOCK_CNT = 2   // consecutive mismatches needed to unlock
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_in,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             match_err,
   output logic             timeout,
   output logic             locked
);

   // --------------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // --------------------------------------------------------------------------
   if (CNT_W < 2) begin : g_bad_cnt_w
      $error("fd_period_monitor: CNT_W must be at least 2");
   end
   if (LOCK_CNT < 1) begin : g_bad_lock_cnt
      $error("fd_period_monitor: LOCK_CNT must be at least 1");
   end
   if (UNLOCK_CNT < 1) begin : g_bad_unlock_cnt
      $error("fd_period_monitor: UNLOCK_CNT must be at least 1");
   end

   // --------------------------------------------------------------------------
   // Constants
   // --------------------------------------------------------------------------
   // Tolerance window is evaluated one bit wider than the counter so that
   // EXP_PERIOD + TOL never wraps; the lower bound clamps at zero.
   localparam int CMP_W  = CNT_W + 1;
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_PRE_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

   localparam logic [CMP_W-1:0] LO_BOUND =
      (EXP_PERIOD > TOL) ? CMP_W'(EXP_PERIOD - TOL) : '0;
   localparam logic [CMP_W-1:0] HI_BOUND = CMP_W'(EXP_PERIOD + TOL);

   // good/bad values on the measurement that completes the transition
   localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_CNT - 1);
   localparam logic [BAD_W-1:0]  UNLOCK_LAST = BAD_W'(UNLOCK_CNT - 1);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_e;

   // --------------------------------------------------------------------------
   // Declarations
   // --------------------------------------------------------------------------
   // div_in synchronizer (s1, s2) and edge register (s3)
   logic             s1_q, s2_q, s3_q;

   // period counter and first-edge flag
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;

   // registered outputs
   logic [CNT_W-1:0] period_q, period_d;
   logic             period_vld_q, period_vld_d;
   logic             match_err_q, match_err_d;
   logic             timeout_q, timeout_d;
   logic             locked_q, locked_d;

   // lock FSM
   state_e           state_q, state_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [BAD_W-1:0]  bad_q, bad_d;

   // per-cycle events
   logic             rise;      // synchronized rising edge of div_in
   logic             meas;      // rise that yields a period measurement
   logic             tmo_hit;   // counter saturates this cycle without an edge
   logic             match;     // current counter value is inside tolerance
   logic [CMP_W-1:0] cnt_ext;

   // --------------------------------------------------------------------------
   // Event decode
   // --------------------------------------------------------------------------
   assign rise    = s2_q & ~s3_q;
   assign meas    = rise & first_q;
   // A rise in the saturating cycle counts as an edge, so it suppresses timeout.
   assign tmo_hit = ~rise & (cnt_q == CNT_PRE_MAX);
   assign cnt_ext = {1'b0, cnt_q};
   assign match   = (cnt_ext >= LO_BOUND) && (cnt_ext <= HI_BOUND);

   // Synchronize div_in into the clk domain and keep one stage for edge detect
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its source; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= div_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Next-state for the period counter, first-edge flag and output pulses
   // NOTE: every signal assigned in always_comb gets a default at the top so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_d        = cnt_q;
      first_d      = first_q;
      period_d     = period_q;
      period_vld_d = 1'b0;
      match_err_d  = 1'b0;
      timeout_d    = 1'b0;

      if (rise) begin
         cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (tmo_hit) begin
         first_d   = 1'b0;
         timeout_d = 1'b1;
      end else if (rise) begin
         first_d = 1'b1;
      end

      if (meas) begin
         period_d     = cnt_q;
         period_vld_d = 1'b1;
         match_err_d  = ~match;
      end
   end

   // Counter and first-edge flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         first_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

   // --------------------------------------------------------------------------
   // Lock FSM
   // --------------------------------------------------------------------------
   // FSM state and good/bad run-length counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_UNLOCKED;
         good_q  <= '0;
         bad_q   <= '0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
      end
   end

   // FSM next state: moves only on a measurement, or is forced down on timeout
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;

      if (tmo_hit) begin
         state_d = ST_UNLOCKED;
         good_d  = '0;
         bad_d   = '0;
      end else if (meas) begin
         unique case (state_q)
            ST_UNLOCKED: begin
               if (match) begin
                  good_d = GOOD_W'(1);
                  if (LOCK_CNT == 1) begin
                     state_d = ST_LOCKED;
                     bad_d   = '0;
                  end else begin
                     state_d = ST_ACQUIRE;
                  end
               end
            end
            ST_ACQUIRE: begin
               if (match) begin
                  good_d = good_q + 1'b1;
                  if (good_q == LOCK_LAST) begin
                     state_d = ST_LOCKED;
                     bad_d   = '0;
                  end
               end else begin
                  good_d  = '0;
                  state_d = ST_UNLOCKED;
               end
            end
            ST_LOCKED: begin
               if (match) begin
                  bad_d = '0;
               end else if (bad_q == UNLOCK_LAST) begin
                  // Leave lock with a clean slate for the next acquisition.
                  state_d = ST_UNLOCKED;
                  good_d  = '0;
                  bad_d   = '0;
               end else begin
                  bad_d = bad_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_UNLOCKED;
               good_d  = '0;
               bad_d   = '0;
            end
         endcase
      end
   end

   // FSM output decode: lock indicator follows the next state so it lands on
   // the same edge as the measurement that caused the transition
   always_comb begin
      locked_d = (state_d == ST_LOCKED);
   end

   // --------------------------------------------------------------------------
   // Output registers
   // --------------------------------------------------------------------------
   // All outputs are registered and update together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_q     <= '0;
         period_vld_q <= 1'b0;
         match_err_q  <= 1'b0;
         timeout_q    <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         period_q     <= period_d;
         period_vld_q <= period_vld_d;
         match_err_q  <= match_err_d;
         timeout_q    <= timeout_d;
         locked_q     <= locked_d;
      end
   end

   assign period     = period_q;
   assign period_vld = period_vld_q;
   assign match_err  = match_err_q;
   assign timeout    = timeout_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_fd_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_fd_period_monitor
//
// Directed bench for fd_period_monitor. dut_a uses default parameters,
// dut_b uses TOL = 1; both share clk, rst_n and div_in. A negedge monitor
// logs every period_vld / timeout pulse with its clk-edge index, and each
// test task compares the log against hand-computed expectations.
//
// Stimulus model: drive_period(p) raises div_in and keeps a p-cycle segment,
// so each rise measures the length of the segment before it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fd_period_monitor;

   typedef struct {
      int         cyc;
      logic [7:0] period;
      logic       err;
      logic       lck;
   } meas_t;

   logic       clk;
   logic       rst_n;
   logic       div_in;
   logic [7:0] period_a, period_b;
   logic       vld_a, vld_b, err_a, err_b, tmo_a, tmo_b, lck_a, lck_b;

   int         n_pass  = 0;
   int         n_total = 0;
   int         cyc     = 0;

   meas_t      q_a[$];
   meas_t      q_b[$];
   int         tmo_cyc[$];
   logic       tmo_lck[$];
   meas_t      missing;
   meas_t      mon_a, mon_b;

   fd_period_monitor dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .div_in     (div_in),
      .period     (period_a),
      .period_vld (vld_a),
      .match_err  (err_a),
      .timeout    (tmo_a),
      .locked     (lck_a)
   );

   fd_period_monitor #(.TOL(1)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .div_in     (div_in),
      .period     (period_b),
      .period_vld (vld_b),
      .match_err  (err_b),
      .timeout    (tmo_b),
      .locked     (lck_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log output pulses away from the active edge
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (vld_a) begin
            mon_a.cyc = cyc; mon_a.period = period_a; mon_a.err = err_a; mon_a.lck = lck_a;
            q_a.push_back(mon_a);
         end
         if (vld_b) begin
            mon_b.cyc = cyc; mon_b.period = period_b; mon_b.err = err_b; mon_b.lck = lck_b;
            q_b.push_back(mon_b);
         end
         if (tmo_a) begin
            tmo_cyc.push_back(cyc);
            tmo_lck.push_back(lck_a);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus helpers
   // --------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_period(input int p);
      div_in = 1'b1;
      repeat (p / 2) step();
      div_in = 1'b0;
      repeat (p - p / 2) step();
   endtask

   task automatic do_reset();
      div_in = 1'b0;
      rst_n  = 1'b0;
      repeat (3) step();
      q_a.delete();
      q_b.delete();
      tmo_cyc.delete();
      tmo_lck.delete();
      rst_n = 1'b1;
      repeat (2) step();
   endtask

   // Bounded wait for n logged measurements, then a few idle cycles so any
   // unexpected extra measurement would also be logged.
   task automatic wait_meas(input bit use_b, input int n);
      for (int i = 0; i < 40; i++) begin
         if ((use_b ? q_b.size() : q_a.size()) >= n) break;
         step();
      end
      repeat (4) step();
   endtask

   // --------------------------------------------------------------------------
   // Tests
   // --------------------------------------------------------------------------
   task automatic test_reset();
      rst_n  = 1'b0;
      div_in = 1'b0;
      repeat (2) step();
      div_in = 1'b1;
      repeat (2) step();
      div_in = 1'b0;
      step();
      n_total++; if (period_a !== 8'd0) $display("FAIL reset_period: got %0d expected 0", period_a); else n_pass++;
      n_total++; if (vld_a !== 1'b0) $display("FAIL reset_vld: got %b expected 0", vld_a); else n_pass++;
      n_total++; if (err_a !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_a); else n_pass++;
      n_total++; if (tmo_a !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", tmo_a); else n_pass++;
      n_total++; if (lck_a !== 1'b0) $display("FAIL reset_locked: got %b expected 0", lck_a); else n_pass++;
   endtask

   // div_in idles high through reset release: that counts as the first
   // (discarded) edge, then a steady divide-by-4 follows.
   task automatic test_lock();
      logic el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      div_in = 1'b1;
      rst_n  = 1'b0;
      repeat (3) step();
      q_a.delete();
      rst_n = 1'b1;
      repeat (2) step();
      div_in = 1'b0;
      repeat (2) step();
      repeat (5) drive_period(4);
      wait_meas(1'b0, 5);
      n_total++; if (q_a.size() != 5) $display("FAIL lock_count: got %0d measurements expected 5", q_a.size()); else n_pass++;
      while (q_a.size() < 5) q_a.push_back(missing);
      for (int i = 0; i < 5; i++) begin
         n_total++; if (q_a[i].period !== 8'd4) $display("FAIL lock_period[%0d]: got %0d expected 4", i, q_a[i].period); else n_pass++;
         n_total++; if (q_a[i].err !== 1'b0) $display("FAIL lock_err[%0d]: got %b expected 0", i, q_a[i].err); else n_pass++;
         n_total++; if (q_a[i].lck !== el[i]) $display("FAIL lock_locked[%0d]: got %b expected %b", i, q_a[i].lck, el[i]); else n_pass++;
         if (i > 0) begin
            n_total++;
            if (q_a[i].cyc - q_a[i-1].cyc != 4)
               $display("FAIL lock_spacing[%0d]: got %0d cycles expected 4", i, q_a[i].cyc - q_a[i-1].cyc);
            else n_pass++;
         end
      end
   endtask

   // Lock on /4, two /6 periods drop lock, back to /4 re-locks after 4 matches.
   task automatic test_unlock();
      logic [7:0] ep [12] = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd6, 8'd6, 8'd6, 8'd4, 8'd4, 8'd4, 8'd4};
      logic       ee [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       el [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      repeat (5) drive_period(4);
      repeat (3) drive_period(6);
      repeat (5) drive_period(4);
      wait_meas(1'b0, 12);
      n_total++; if (q_a.size() != 12) $display("FAIL unlock_count: got %0d measurements expected 12", q_a.size()); else n_pass++;
      while (q_a.size() < 12) q_a.push_back(missing);
      for (int i = 0; i < 12; i++) begin
         n_total++; if (q_a[i].period !== ep[i]) $display("FAIL unlock_period[%0d]: got %0d expected %0d", i, q_a[i].period, ep[i]); else n_pass++;
         n_total++; if (q_a[i].err !== ee[i]) $display("FAIL unlock_err[%0d]: got %b expected %b", i, q_a[i].err, ee[i]); else n_pass++;
         n_total++; if (q_a[i].lck !== el[i]) $display("FAIL unlock_locked[%0d]: got %b expected %b", i, q_a[i].lck, el[i]); else n_pass++;
      end
   endtask

   // TOL = 1 instance: alternating 3/5 locks cleanly, a 6 is out of window.
   task automatic test_tolerance();
      int         seq [6] = '{3, 5, 3, 5, 6, 4};
      logic [7:0] ep  [5] = '{8'd3, 8'd5, 8'd3, 8'd5, 8'd6};
      logic       ee  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic       el  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset();
      for (int i = 0; i < 6; i++) drive_period(seq[i]);
      wait_meas(1'b1, 5);
      n_total++; if (q_b.size() != 5) $display("FAIL tol_count: got %0d measurements expected 5", q_b.size()); else n_pass++;
      while (q_b.size() < 5) q_b.push_back(missing);
      for (int i = 0; i < 5; i++) begin
         n_total++; if (q_b[i].period !== ep[i]) $display("FAIL tol_period[%0d]: got %0d expected %0d", i, q_b[i].period, ep[i]); else n_pass++;
         n_total++; if (q_b[i].err !== ee[i]) $display("FAIL tol_err[%0d]: got %b expected %b", i, q_b[i].err, ee[i]); else n_pass++;
         n_total++; if (q_b[i].lck !== el[i]) $display("FAIL tol_locked[%0d]: got %b expected %b", i, q_b[i].lck, el[i]); else n_pass++;
      end
   endtask

   // One period of 7 while locked: single match_err, lock is held.
   task automatic test_glitch();
      logic [7:0] ep [8] = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd7, 8'd4, 8'd4};
      logic       ee [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       el [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      do_reset();
      repeat (5) drive_period(4);
      drive_period(7);
      repeat (3) drive_period(4);
      wait_meas(1'b0, 8);
      n_total++; if (q_a.size() != 8) $display("FAIL glitch_count: got %0d measurements expected 8", q_a.size()); else n_pass++;
      while (q_a.size() < 8) q_a.push_back(missing);
      for (int i = 0; i < 8; i++) begin
         n_total++; if (q_a[i].period !== ep[i]) $display("FAIL glitch_period[%0d]: got %0d expected %0d", i, q_a[i].period, ep[i]); else n_pass++;
         n_total++; if (q_a[i].err !== ee[i]) $display("FAIL glitch_err[%0d]: got %b expected %b", i, q_a[i].err, ee[i]); else n_pass++;
         n_total++; if (q_a[i].lck !== el[i]) $display("FAIL glitch_locked[%0d]: got %b expected %b", i, q_a[i].lck, el[i]); else n_pass++;
      end
   endtask

   // Lock, then stop div_in. rise is high in the cycle before the vld edge of
   // the last measurement, so the timeout edge is 254 edges after that vld
   // edge (255 cycles after rise). Afterwards the first edge is discarded.
   task automatic test_timeout();
      int last_cyc;
      do_reset();
      repeat (5) drive_period(4);
      wait_meas(1'b0, 4);
      n_total++; if (q_a.size() != 4) $display("FAIL tmo_pre_count: got %0d measurements expected 4", q_a.size()); else n_pass++;
      while (q_a.size() < 4) q_a.push_back(missing);
      n_total++; if (q_a[3].lck !== 1'b1) $display("FAIL tmo_pre_locked: got %b expected 1", q_a[3].lck); else n_pass++;
      last_cyc = q_a[3].cyc;
      for (int i = 0; i < 400; i++) begin
         if (tmo_cyc.size() > 0) break;
         step();
      end
      repeat (20) step();
      n_total++; if (tmo_cyc.size() != 1) $display("FAIL tmo_pulses: got %0d pulses expected 1", tmo_cyc.size()); else n_pass++;
      if (tmo_cyc.size() > 0) begin
         n_total++;
         if (tmo_cyc[0] - last_cyc != 254) $display("FAIL tmo_delay: got %0d edges expected 254", tmo_cyc[0] - last_cyc);
         else n_pass++;
         n_total++; if (tmo_lck[0] !== 1'b0) $display("FAIL tmo_locked: got %b expected 0", tmo_lck[0]); else n_pass++;
      end
      n_total++; if (lck_a !== 1'b0) $display("FAIL tmo_locked_after: got %b expected 0", lck_a); else n_pass++;
      q_a.delete();
      repeat (3) drive_period(4);
      wait_meas(1'b0, 2);
      n_total++; if (q_a.size() != 2) $display("FAIL tmo_resume_count: got %0d measurements expected 2", q_a.size()); else n_pass++;
      while (q_a.size() < 2) q_a.push_back(missing);
      for (int i = 0; i < 2; i++) begin
         n_total++; if (q_a[i].period !== 8'd4) $display("FAIL tmo_resume_period[%0d]: got %0d expected 4", i, q_a[i].period); else n_pass++;
         n_total++; if (q_a[i].lck !== 1'b0) $display("FAIL tmo_resume_locked[%0d]: got %b expected 0", i, q_a[i].lck); else n_pass++;
      end
   endtask

   // Reset after two matches: outputs clear without a clock edge, and the
   // following acquisition needs one discarded edge plus four matches.
   task automatic test_reset_mid();
      logic el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      repeat (3) drive_period(4);
      wait_meas(1'b0, 2);
      n_total++; if (q_a.size() != 2) $display("FAIL rmid_pre_count: got %0d measurements expected 2", q_a.size()); else n_pass++;
      n_total++; if (period_a !== 8'd4) $display("FAIL rmid_pre_period: got %0d expected 4", period_a); else n_pass++;
      #2;
      rst_n  = 1'b0;
      div_in = 1'b0;
      #1;
      n_total++; if (period_a !== 8'd0) $display("FAIL rmid_period: got %0d expected 0", period_a); else n_pass++;
      n_total++; if (vld_a !== 1'b0) $display("FAIL rmid_vld: got %b expected 0", vld_a); else n_pass++;
      n_total++; if (err_a !== 1'b0) $display("FAIL rmid_err: got %b expected 0", err_a); else n_pass++;
      n_total++; if (tmo_a !== 1'b0) $display("FAIL rmid_timeout: got %b expected 0", tmo_a); else n_pass++;
      n_total++; if (lck_a !== 1'b0) $display("FAIL rmid_locked: got %b expected 0", lck_a); else n_pass++;
      repeat (2) step();
      q_a.delete();
      rst_n = 1'b1;
      repeat (2) step();
      repeat (5) drive_period(4);
      wait_meas(1'b0, 4);
      n_total++; if (q_a.size() != 4) $display("FAIL rmid_count: got %0d measurements expected 4", q_a.size()); else n_pass++;
      while (q_a.size() < 4) q_a.push_back(missing);
      for (int i = 0; i < 4; i++) begin
         n_total++; if (q_a[i].period !== 8'd4) $display("FAIL rmid_period[%0d]: got %0d expected 4", i, q_a[i].period); else n_pass++;
         n_total++; if (q_a[i].lck !== el[i]) $display("FAIL rmid_locked[%0d]: got %b expected %b", i, q_a[i].lck, el[i]); else n_pass++;
      end
   endtask

   // --------------------------------------------------------------------------
   // Sequencer and watchdog
   // --------------------------------------------------------------------------
   initial begin
      missing.cyc    = -1;
      missing.period = 'x;
      missing.err    = 1'bx;
      missing.lck    = 1'bx;
      rst_n  = 1'b0;
      div_in = 1'b0;
      test_reset();
      test_lock();
      test_unlock();
      test_tolerance();
      test_glitch();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed so far", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule
